sb_dmem_ctrl: RTL and testbench
===============================

Name: sb_dmem_ctrl

Overview:
- Responder end of the core's data-memory interface, on the system-bus side.
- Accepts load/store requests from the core's execute stage: re/we, address, size mask, unsigned flag and write data.
- Drives a single-port synchronous word SRAM with 1-cycle read latency.
- Returns aligned, sign- or zero-extended load data to the register-file write path, with a ready handshake that stalls the core.

Parameters:
- DEPTH_WORDS, 4096: SRAM depth in 32-bit words; power of two.
- RAM_AW, $clog2(DEPTH_WORDS): SRAM word-address width.
- BASE_ADDR, 32'h0000_0000: byte address mapped to SRAM word 0.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_re_i  input  1  load request.
- mem_we_i  input  1  store request.
- addr_i  input  32  byte address.
- byte_mask_i  input  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word; any other value is illegal.
- un_sign_i  input  1  1 = zero-extend load, 0 = sign-extend.
- wdata_i  input  32  store data, right-justified.
- rdata_o  output  32  formatted load data.
- ready_o  output  1  request complete; 0 = core must hold.
- err_o  output  1  one-cycle pulse on an illegal request.
- ram_en_o  output  1  SRAM enable.
- ram_we_o  output  4  SRAM byte write enables.
- ram_addr_o  output  RAM_AW  SRAM word address.
- ram_wdata_o  output  32  SRAM write data, lane-shifted.
- ram_rdata_i  input  32  SRAM read data, valid the cycle after ram_en_o with ram_we_o = 0.

Behaviour:
- Reset: state = IDLE; rdata_o = 0; err_o = 0; ram_en_o = 0; ram_we_o = 0; ram_addr_o = 0; ram_wdata_o = 0.
- ready_o is combinational from state and request: 1 in IDLE when no request or on a store/error; 0 on a legal load in IDLE.
- Reset asserted in any state returns to IDLE the next edge. Any pending read response is discarded and no RAM access is issued during reset.
- Offset: off = addr_i - BASE_ADDR.
- Word index: ram_addr_o = off[RAM_AW+1:2].
- Lane: lane = off[1:0].
- Illegal request (err_o pulses next cycle, no RAM access, ready_o = 1 in the request cycle, rdata_o cleared to 0):
  - mem_re_i and mem_we_i both high;
  - byte_mask_i not one of the three legal encodings;
  - half access with lane[0] = 1;
  - word access with lane != 0;
  - off >= 4*DEPTH_WORDS, or addr_i < BASE_ADDR.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE, legal store:
  - ram_en_o = 1;
  - ram_we_o = byte_mask_i << lane;
  - ram_wdata_o = wdata_i << (8*lane);
  - ready_o = 1 the same cycle; stay in IDLE.
  - Back-to-back stores complete at one per cycle.
- IDLE, legal load:
  - ram_en_o = 1, ram_we_o = 0; ready_o = 0;
  - capture lane, mask and un_sign into registers; go to RD_WAIT.
- RD_WAIT:
  - ready_o = 0;
  - shift ram_rdata_i right by 8*lane_q;
  - extend by mask_q and un_sign_q: byte from bit 7, half from bit 15, word unchanged;
  - register the result into rdata_o; go to RESP.
- RESP:
  - ready_o = 1; rdata_o holds its value; no RAM access; go to IDLE.
  - A new request is sampled only in IDLE, so load-to-next-request spacing is 3 cycles.
- Load latency: request at cycle T, ready_o = 1 and rdata_o valid at T+2.
- rdata_o holds its last value until the next load completes or an error clears it.
- The core holds mem_re_i and its address stable until it sees ready_o. Input changes during RD_WAIT and RESP are ignored.
- Stores never modify bytes outside ram_we_o. The controller performs no read-modify-write.

Test Plan:
- Store then load word: store addr 0x10, wdata 0xDEADBEEF, mask 1111 -> ram_we_o = 1111 and ready_o = 1 the same cycle. Load 0x10 -> ready_o = 1 two cycles later, rdata_o = 0xDEADBEEF.
- Byte store lanes: store 0xA5 at addr 0x13, mask 0001 -> ram_we_o = 1000, ram_wdata_o = 0xA5000000. Load signed byte 0x13 -> 0xFFFFFFA5. Load unsigned byte 0x13 -> 0x000000A5.
- Half access: word 0x20 = 0x8001_7FFF. Signed half at 0x22 -> 0xFFFF8001. Unsigned half at 0x22 -> 0x00008001. Signed half at 0x20 -> 0x00007FFF.
- Illegal requests: word load at 0x21; re and we both high; addr = 4*DEPTH_WORDS -> each gives err_o one-cycle pulse, ready_o = 1, ram_en_o = 0, rdata_o = 0.
- Reset mid-load: assert rst in RD_WAIT -> next cycle state = IDLE, ready_o = 1 with no request, rdata_o = 0. A subsequent load of 0x10 returns the correct data.
- Throughput: 4 back-to-back word stores to 0x0, 0x4, 0x8, 0xC -> 4 consecutive cycles with ready_o = 1. Two consecutive loads -> ready_o pattern 0,0,1,0,0,1.

Source files
------------

// File: rtl/sb_dmem_ctrl.sv
// Data-memory responder: turns core load/store requests into single-port SRAM
// accesses and returns lane-aligned, sign/zero-extended load data.

module sb_dmem_wlane #(
    parameter int LANE_ID = 0
) (
    input  logic [1:0]  lane,
    input  logic [3:0]  mask,
    input  logic [31:0] wdata,
    output logic        we,
    output logic [7:0]  wbyte
);
    // Source byte feeding this SRAM lane; k[2] set means the lane lies below the shift.
    logic [2:0] k;

    always_comb begin
        k     = 3'(LANE_ID) - {1'b0, lane};
        we    = ~k[2] & mask[k[1:0]];
        wbyte = k[2] ? 8'h00 : wdata[{k[1:0], 3'b000} +: 8];
    end
endmodule

module sb_dmem_ctrl #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RAM_AW      = $clog2(DEPTH_WORDS),
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_re_i,
    input  logic              mem_we_i,
    input  logic [31:0]       addr_i,
    input  logic [3:0]        byte_mask_i,
    input  logic              un_sign_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ready_o,
    output logic              err_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    state_t      state;
    logic [1:0]  lane_q;
    logic [3:0]  mask_q;
    logic        un_sign_q;

    logic [31:0] off;
    logic [1:0]  lane;
    logic        is_b, is_h, is_w;
    logic        req, illegal, ld_ok, do_st, do_ld;
    logic [3:0]  we_l;
    logic [3:0][7:0] wd_l;
    logic [31:0] shifted, fmt;

    always_comb begin
        off     = addr_i - BASE_ADDR;
        lane    = off[1:0];
        is_b    = (byte_mask_i == 4'b0001);
        is_h    = (byte_mask_i == 4'b0011);
        is_w    = (byte_mask_i == 4'b1111);
        req     = mem_re_i | mem_we_i;
        illegal = req & ((mem_re_i & mem_we_i)
                       | ~(is_b | is_h | is_w)
                       | (is_h & lane[0])
                       | (is_w & (lane != 2'b00))
                       | (addr_i < BASE_ADDR)
                       | ({1'b0, off} >= SPAN));
        ld_ok   = mem_re_i & ~illegal;
        do_st   = (state == IDLE) & ~rst & mem_we_i & ~illegal;
        do_ld   = (state == IDLE) & ~rst & ld_ok;
    end

    // Write steering: each SRAM byte lane picks its source byte from the shifted request.
    for (genvar i = 0; i < 4; i++) begin : g_wlane
        sb_dmem_wlane #(.LANE_ID(i)) u_wlane (
            .lane  (lane),
            .mask  (byte_mask_i),
            .wdata (wdata_i),
            .we    (we_l[i]),
            .wbyte (wd_l[i])
        );
    end

    always_comb begin
        ready_o     = (state == RESP) | ((state == IDLE) & ~ld_ok);
        ram_en_o    = do_st | do_ld;
        ram_we_o    = do_st ? we_l : 4'b0000;
        ram_addr_o  = (do_st | do_ld) ? off[RAM_AW+1:2] : '0;
        ram_wdata_o = do_st ? wd_l : 32'h0;
    end

    always_comb begin
        shifted = ram_rdata_i >> {lane_q, 3'b000};
        case (mask_q)
            4'b0001: fmt = un_sign_q ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            4'b0011: fmt = un_sign_q ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            default: fmt = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdata_o   <= 32'h0;
            err_o     <= 1'b0;
            lane_q    <= 2'b00;
            mask_q    <= 4'b0000;
            un_sign_q <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (illegal) begin
                        err_o   <= 1'b1;
                        rdata_o <= 32'h0;
                    end else if (mem_re_i) begin
                        lane_q    <= lane;
                        mask_q    <= byte_mask_i;
                        un_sign_q <= un_sign_i;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    rdata_o <= fmt;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sb_dmem_ctrl.sv
// Directed bench for sb_dmem_ctrl with a behavioural 1-cycle-latency SRAM.

module tb_sb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        re, we, un_sign;
    logic [31:0] addr, wd;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        ready, err, ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [4096];

    always #5 clk = ~clk;

    sb_dmem_ctrl #(.DEPTH_WORDS(4096), .RAM_AW(12), .BASE_ADDR(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_re_i    (re),
        .mem_we_i    (we),
        .addr_i      (addr),
        .byte_mask_i (mask),
        .un_sign_i   (un_sign),
        .wdata_i     (wd),
        .rdata_o     (rdata),
        .ready_o     (ready),
        .err_o       (err),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of request inputs; returns mid-cycle, ready for sampling.
    task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] m, input logic u, input logic [31:0] d);
        @(posedge clk);
        #1;
        re = r; we = w; addr = a; mask = m; un_sign = u; wd = d;
        #3;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    endtask

    task automatic st(input string tag, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d, input logic [3:0] exp_we, input logic [31:0] exp_wd);
        cyc(1'b0, 1'b1, a, m, 1'b0, d);
        chk({tag, ".ready"}, 32'(ready), 32'd1);
        chk({tag, ".en"},    32'(ram_en), 32'd1);
        chk({tag, ".we"},    32'(ram_we), 32'(exp_we));
        chk({tag, ".wdata"}, ram_wdata, exp_wd);
        chk({tag, ".addr"},  32'(ram_addr), 32'(a[13:2]));
    endtask

    // Holds the request through RD_WAIT and RESP, as the core would.
    task automatic ld(input string tag, input logic [31:0] a, input logic [3:0] m,
                      input logic u, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, m, u, 32'h0);
        chk({tag, ".ready0"}, 32'(ready), 32'd0);
        chk({tag, ".en"},     32'(ram_en), 32'd1);
        chk({tag, ".we"},     32'(ram_we), 32'd0);
        chk({tag, ".addr"},   32'(ram_addr), 32'(a[13:2]));
        cyc(1'b1, 1'b0, a, m, u, 32'h0);
        chk({tag, ".ready1"}, 32'(ready), 32'd0);
        chk({tag, ".en_wait"}, 32'(ram_en), 32'd0);
        cyc(1'b1, 1'b0, a, m, u, 32'h0);
        chk({tag, ".ready2"}, 32'(ready), 32'd1);
        chk({tag, ".en_resp"}, 32'(ram_en), 32'd0);
        chk({tag, ".rdata"},  rdata, exp);
    endtask

    task automatic bad(input string tag, input logic r, input logic w,
                       input logic [31:0] a, input logic [3:0] m);
        cyc(r, w, a, m, 1'b0, 32'h5555_5555);
        chk({tag, ".ready"}, 32'(ready), 32'd1);
        chk({tag, ".en"},    32'(ram_en), 32'd0);
        chk({tag, ".we"},    32'(ram_we), 32'd0);
        idle();
        chk({tag, ".err"},   32'(err), 32'd1);
        chk({tag, ".rdata"}, rdata, 32'h0);
        idle();
        chk({tag, ".err_end"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b1; addr = 32'h10; mask = 4'b1111;
        un_sign = 1'b0; wd = 32'h1111_1111;
        repeat (2) @(posedge clk);
        #3;
        chk("rst.en",    32'(ram_en), 32'd0);
        chk("rst.we",    32'(ram_we), 32'd0);
        chk("rst.addr",  32'(ram_addr), 32'd0);
        chk("rst.wdata", ram_wdata, 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.err",   32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; we = 1'b0;
        #3;
        chk("rst.ready_idle", 32'(ready), 32'd1);

        st("st_w10",  32'h10, 4'b1111, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        ld("ld_w10",  32'h10, 4'b1111, 1'b0, 32'hDEAD_BEEF);
        st("st_b13",  32'h13, 4'b0001, 32'h0000_00A5, 4'b1000, 32'hA500_0000);
        ld("ld_sb13", 32'h13, 4'b0001, 1'b0, 32'hFFFF_FFA5);
        ld("ld_ub13", 32'h13, 4'b0001, 1'b1, 32'h0000_00A5);
        ld("ld_sb11", 32'h11, 4'b0001, 1'b0, 32'hFFFF_FFBE);

        st("st_w20",  32'h20, 4'b1111, 32'h8001_7FFF, 4'b1111, 32'h8001_7FFF);
        ld("ld_sh22", 32'h22, 4'b0011, 1'b0, 32'hFFFF_8001);
        ld("ld_uh22", 32'h22, 4'b0011, 1'b1, 32'h0000_8001);
        ld("ld_sh20", 32'h20, 4'b0011, 1'b0, 32'h0000_7FFF);
        st("st_h22",  32'h22, 4'b0011, 32'h0000_1234, 4'b1100, 32'h1234_0000);
        ld("ld_w20",  32'h20, 4'b1111, 1'b0, 32'h1234_7FFF);

        bad("bad_mis_w", 1'b1, 1'b0, 32'h21, 4'b1111);
        bad("bad_rewe",  1'b1, 1'b1, 32'h10, 4'b1111);
        bad("bad_oor",   1'b1, 1'b0, 32'h4000, 4'b1111);
        bad("bad_mask",  1'b1, 1'b0, 32'h10, 4'b0101);
        bad("bad_mis_h", 1'b0, 1'b1, 32'h21, 4'b0011);

        st("st_top", 32'h3FFC, 4'b1111, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        ld("ld_top", 32'h3FFC, 4'b1111, 1'b0, 32'hCAFE_F00D);

        // Reset while the load is in RD_WAIT
        cyc(1'b1, 1'b0, 32'h10, 4'b1111, 1'b0, 32'h0);
        chk("rstld.ready0", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        chk("rstld.en_in_rst", 32'(ram_en), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; re = 1'b0;
        #3;
        chk("rstld.ready", 32'(ready), 32'd1);
        chk("rstld.rdata", rdata, 32'h0);
        chk("rstld.en",    32'(ram_en), 32'd0);
        ld("rstld.reload", 32'h10, 4'b1111, 1'b0, 32'hA5AD_BEEF);

        st("tp_st0", 32'h0, 4'b1111, 32'h1111_1111, 4'b1111, 32'h1111_1111);
        st("tp_st1", 32'h4, 4'b1111, 32'h2222_2222, 4'b1111, 32'h2222_2222);
        st("tp_st2", 32'h8, 4'b1111, 32'h3333_3333, 4'b1111, 32'h3333_3333);
        st("tp_st3", 32'hC, 4'b1111, 32'h4444_4444, 4'b1111, 32'h4444_4444);
        ld("tp_ld0", 32'h4, 4'b1111, 1'b0, 32'h2222_2222);
        ld("tp_ld1", 32'hC, 4'b1111, 1'b0, 32'h4444_4444);
        idle();
        chk("tp.err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
